// File: rtl/morph_pkg.sv
// Shared types and defaults for the morphology stage scheduler.
package morph_pkg;

    localparam int unsigned STAGES_DEF = 4;

    typedef enum logic [1:0] {
        BYPASS,
        RUN,
        FLUSH
    } sched_state_t;

endpackage

// File: rtl/morph_sched_frame_edge.sv
// Registers vert_sync and step once, then detects edges on the registered copies.
module frame_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic vert_sync,
    input  logic step,
    output logic fb,
    output logic step_rise
);

    logic vs_q, vs_qq;
    logic st_q, st_qq;

    // vert_sync idles high, so its history resets high to avoid a spurious boundary
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            st_q  <= 1'b0;
            st_qq <= 1'b0;
        end else begin
            vs_q  <= vert_sync;
            vs_qq <= vs_q;
            st_q  <= step;
            st_qq <= st_q;
        end
    end

    assign fb        = vs_qq & ~vs_q;
    assign step_rise = st_q & ~st_qq;

endmodule

// File: rtl/morph_sched.sv
// Frame-synchronous scheduler for the erosion/dilation chain: picks per-stage ops,
// applies changes only at frame boundaries and flushes the stages after each change.
module morph_sched
    import morph_pkg::*;
#(
    parameter int unsigned STAGES       = STAGES_DEF,
    parameter int unsigned DWELL_FRAMES = 60,
    parameter int unsigned FLUSH_CYCLES = 800
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vert_sync,
    input  logic              auto_mode,
    input  logic              step,
    input  logic [STAGES-1:0] manual_cfg,
    input  logic              bypass,
    output logic [STAGES-1:0] proc_what,
    output logic              stage_flush,
    output logic              show_orig,
    output logic [STAGES-1:0] cfg_index,
    output logic [15:0]       frame_count
);

    localparam int unsigned DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    sched_state_t      state;
    logic              fb, step_rise;
    logic              step_latch;
    logic              auto_q;
    logic [DW-1:0]     dwell;
    logic [FW-1:0]     flush_cnt;
    logic [STAGES-1:0] pending, pend_d, pw_d;
    logic              expire, apply;

    frame_edge u_frame_edge (
        .clock     (clock),
        .reset_n   (reset_n),
        .vert_sync (vert_sync),
        .step      (step),
        .fb        (fb),
        .step_rise (step_rise)
    );

    // The FSM compares against the next pending value so a dwell expiry lands on its own fb
    always_comb begin
        expire = fb && (dwell == DWELL_LAST);
        pend_d = pending;
        if (auto_mode) begin
            if (expire || step_latch)
                pend_d = cfg_index + STAGES'(1);
        end else begin
            pend_d = manual_cfg;
        end
        pw_d = '0;
        for (int unsigned i = 0; i < STAGES; i++)
            pw_d[STAGES-1-i] = pend_d[i];
        apply = fb && (state == RUN) && !bypass && (pend_d != cfg_index);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_q      <= 1'b0;
            pending     <= '0;
            step_latch  <= 1'b0;
            frame_count <= '0;
            dwell       <= '0;
        end else begin
            auto_q     <= auto_mode;
            pending    <= pend_d;
            step_latch <= step_rise | (step_latch & ~fb);
            if (fb)
                frame_count <= frame_count + 16'd1;
            // Saturate so an expiry seen outside RUN stays armed until it can apply
            if (apply || (auto_mode != auto_q))
                dwell <= '0;
            else if (fb && (dwell != DWELL_LAST))
                dwell <= dwell + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BYPASS;
            flush_cnt   <= '0;
            cfg_index   <= '0;
            proc_what   <= '0;
            stage_flush <= 1'b1;
            show_orig   <= 1'b1;
        end else begin
            case (state)
                BYPASS: begin
                    if (fb && !bypass) begin
                        state       <= FLUSH;
                        flush_cnt   <= FLUSH_LAST;
                        show_orig   <= 1'b0;
                        stage_flush <= 1'b1;
                    end
                end
                RUN: begin
                    if (fb && bypass) begin
                        state       <= BYPASS;
                        show_orig   <= 1'b1;
                        stage_flush <= 1'b1;
                    end else if (apply) begin
                        state       <= FLUSH;
                        flush_cnt   <= FLUSH_LAST;
                        cfg_index   <= pend_d;
                        proc_what   <= pw_d;
                        stage_flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fb && bypass) begin
                        state     <= BYPASS;
                        show_orig <= 1'b1;
                    end else if (flush_cnt == '0) begin
                        state       <= RUN;
                        stage_flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: begin
                    state       <= BYPASS;
                    show_orig   <= 1'b1;
                    stage_flush <= 1'b1;
                end
            endcase
        end
    end

endmodule
